// File: rtl/ltc2333_pkg.sv
// Shared LTC2333 definitions: scheduler state encoding and the 8-bit
// conversion config word used by both the scheduler and the serial engine.
package ltc2333_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_TICK,
    S_ISSUE,
    S_WAIT_DONE
  } sched_state_t;

  localparam logic CFG_CTRL_BIT = 1'b1;

  function automatic logic [7:0] make_cfg(input logic [2:0] chan, input logic [2:0] rng);
    return {CFG_CTRL_BIT, chan, rng, 1'b0};
  endfunction

endpackage

// File: rtl/ltc2333_period_timer.sv
// Free-running frame pacer: one-cycle tick every max(period, MIN_PERIOD) clocks.
// The period is captured on load and held until the next load.
module ltc2333_period_timer #(
  parameter int MIN_PERIOD = 32
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_load,
  input  logic        i_enable,
  input  logic [31:0] i_period,
  output logic        o_tick
);

  logic [31:0] w_eff;
  logic [31:0] r_reload;
  logic [31:0] r_cnt;

  assign w_eff  = (i_period < 32'(MIN_PERIOD)) ? 32'(MIN_PERIOD) : i_period;
  assign o_tick = i_enable && (r_cnt == '0);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_reload <= '0;
      r_cnt    <= '0;
    end else if (i_load) begin
      r_reload <= w_eff - 32'd1;
      r_cnt    <= w_eff - 32'd1;
    end else if (i_enable) begin
      r_cnt <= (r_cnt == '0) ? r_reload : r_cnt - 32'd1;
    end
  end

endmodule

// File: rtl/ltc2333_conv_scheduler.sv
// LTC2333 conversion scheduler: paces frames, walks the enabled channel mask
// and hands one conversion request at a time to the serial engine.
module ltc2333_conv_scheduler
  import ltc2333_pkg::*;
#(
  parameter int MIN_PERIOD = 32,
  parameter int N_CH       = 8,
  parameter int CNT_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [31:0]      i_sample_period,
  input  logic [15:0]      i_n_reads,
  input  logic [N_CH-1:0]  i_active_channels,
  input  logic [2:0]       i_range,
  input  logic             i_mode,
  output logic             o_req_valid,
  input  logic             i_req_ready,
  output logic [7:0]       o_req_cfg,
  output logic             o_req_last,
  input  logic             i_conv_done,
  output logic             o_in_progress,
  output logic [CNT_W-1:0] o_frames_done,
  output logic [CNT_W-1:0] o_overrun_cnt,
  output logic             o_cfg_error
);

  localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  sched_state_t     r_state, w_state_nxt;
  logic [N_CH-1:0]  r_mask, r_issued, w_remaining;
  logic [CNT_W-1:0] r_n_reads, r_frames, r_overrun;
  logic [2:0]       r_range;
  logic             r_mode, r_cur_last, r_abort_pend, r_cfg_error;
  logic [PTR_W-1:0] r_ptr, r_cur_chan, w_sel_chan, w_idx;
  logic             w_sel_last, w_tick, w_xfer, w_start_ok, w_cfg_err;
  logic             w_frame_done, w_abort_arm, w_overrun_evt;

  ltc2333_period_timer #(.MIN_PERIOD(MIN_PERIOD)) u_timer (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_load   (w_start_ok),
    .i_enable (r_state != S_IDLE),
    .i_period (i_sample_period),
    .o_tick   (w_tick)
  );

  // Mode 1 scans upward from the pointer with wrap; mode 0 takes the lowest not-yet-issued channel.
  always_comb begin
    w_remaining = r_mask & ~r_issued;
    w_sel_chan  = '0;
    w_sel_last  = 1'b1;
    w_idx       = '0;
    if (r_mode) begin
      for (int i = N_CH - 1; i >= 0; i--) begin
        w_idx = PTR_W'((int'(r_ptr) + i) % N_CH);
        if (r_mask[w_idx]) w_sel_chan = w_idx;
      end
    end else begin
      for (int i = N_CH - 1; i >= 0; i--) begin
        if (w_remaining[PTR_W'(i)]) w_sel_chan = PTR_W'(i);
      end
      w_sel_last = ((w_remaining & (w_remaining - N_CH'(1))) == '0);
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_start_ok   = 1'b0;
    w_cfg_err    = 1'b0;
    w_frame_done = 1'b0;
    w_abort_arm  = 1'b0;
    w_xfer       = 1'b0;
    o_req_valid  = 1'b0;
    o_req_cfg    = '0;
    o_req_last   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (i_active_channels == '0) begin
            w_cfg_err = 1'b1;
          end else begin
            w_start_ok  = 1'b1;
            w_state_nxt = S_ISSUE;
          end
        end
      end
      S_WAIT_TICK: begin
        if (i_abort)     w_state_nxt = S_IDLE;
        else if (w_tick) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        o_req_valid = 1'b1;
        o_req_cfg   = make_cfg(3'(w_sel_chan), r_range);
        o_req_last  = w_sel_last;
        w_xfer      = i_req_ready;
        if (w_xfer) begin
          w_state_nxt = S_WAIT_DONE;
          w_abort_arm = i_abort;
        end else if (i_abort) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        w_abort_arm = i_abort;
        if (i_conv_done) begin
          if (r_abort_pend || i_abort) begin
            w_state_nxt = S_IDLE;
          end else if (!r_cur_last) begin
            w_state_nxt = S_ISSUE;
          end else begin
            w_frame_done = 1'b1;
            if ((r_n_reads != '0) && (r_frames + CNT_W'(1) == r_n_reads)) w_state_nxt = S_IDLE;
            else                                                        w_state_nxt = S_WAIT_TICK;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_overrun_evt = w_tick && ((r_state == S_ISSUE) || (r_state == S_WAIT_DONE));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_mask       <= '0;
      r_issued     <= '0;
      r_n_reads    <= '0;
      r_frames     <= '0;
      r_overrun    <= '0;
      r_range      <= '0;
      r_mode       <= 1'b0;
      r_cur_last   <= 1'b0;
      r_cur_chan   <= '0;
      r_abort_pend <= 1'b0;
      r_cfg_error  <= 1'b0;
      r_ptr        <= '0;
    end else begin
      r_cfg_error <= w_cfg_err;
      if (w_start_ok) begin
        r_mask       <= i_active_channels;
        r_n_reads    <= CNT_W'(i_n_reads);
        r_range      <= i_range;
        r_mode       <= i_mode;
        r_frames     <= '0;
        r_overrun    <= '0;
        r_issued     <= '0;
        r_abort_pend <= 1'b0;
      end else begin
        if (w_overrun_evt && (r_overrun != '1)) r_overrun <= r_overrun + CNT_W'(1);
        if (w_abort_arm) r_abort_pend <= 1'b1;
        if (w_xfer) begin
          r_issued[w_sel_chan] <= 1'b1;
          r_cur_chan           <= w_sel_chan;
          r_cur_last           <= w_sel_last;
        end
        // The round-robin pointer only moves on completed frames, so an aborted frame is retried.
        if (w_frame_done) begin
          r_frames <= r_frames + CNT_W'(1);
          r_issued <= '0;
          if (r_mode) r_ptr <= (r_cur_chan == PTR_W'(N_CH - 1)) ? '0 : r_cur_chan + PTR_W'(1);
        end
      end
    end
  end

  assign o_in_progress = (r_state != S_IDLE);
  assign o_frames_done = r_frames;
  assign o_overrun_cnt = r_overrun;
  assign o_cfg_error   = r_cfg_error;

endmodule

// File: tb/tb_ltc2333_conv_scheduler.sv
// Scoreboarded bench for ltc2333_conv_scheduler: directed runs push expected
// requests (cfg, last, transfer edge); a negedge monitor pops and compares.
module tb_ltc2333_conv_scheduler;

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0;
  logic        req_ready = 1'b1, conv_done = 1'b0, mode = 1'b0;
  logic [31:0] sample_period = '0;
  logic [15:0] n_reads = '0;
  logic [7:0]  active_channels = '0;
  logic [2:0]  rng = '0;
  logic        req_valid, req_last, in_progress, cfg_error;
  logic [7:0]  req_cfg;
  logic [15:0] frames_done, overrun_cnt;

  int cyc = 0, checks = 0, failures = 0, resp_delay = 5;
  int S, fall, stable;

  typedef struct {
    logic [7:0] cfg;
    logic       last;
    int         edge_no;
  } exp_t;
  exp_t exp_q[$];

  ltc2333_conv_scheduler dut (
    .i_clk             (clk),
    .i_reset           (reset),
    .i_start           (start),
    .i_abort           (abort),
    .i_sample_period   (sample_period),
    .i_n_reads         (n_reads),
    .i_active_channels (active_channels),
    .i_range           (rng),
    .i_mode            (mode),
    .o_req_valid       (req_valid),
    .i_req_ready       (req_ready),
    .o_req_cfg         (req_cfg),
    .o_req_last        (req_last),
    .i_conv_done       (conv_done),
    .o_in_progress     (in_progress),
    .o_frames_done     (frames_done),
    .o_overrun_cnt     (overrun_cnt),
    .o_cfg_error       (cfg_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [7:0] c, input logic l, input int e);
    exp_t x;
    x.cfg = c; x.last = l; x.edge_no = e;
    exp_q.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step();
  endtask

  task automatic wait_idle(input int budget, output int f);
    f = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (!in_progress) begin
        f = cyc;
        break;
      end
    end
    if (f < 0) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout: in_progress still 1 after %0d cycles, expected 0", budget);
    end
  endtask

  // Inputs are scrambled after the start pulse to show the run uses its latched copy.
  task automatic start_run(input logic [31:0] per, input logic [15:0] nr, input logic [7:0] msk,
                           input logic [2:0] r, input logic md);
    sample_period = per; n_reads = nr; active_channels = msk; rng = r; mode = md;
    start = 1'b1;
    step();
    start = 1'b0;
    sample_period = 32'd7; n_reads = 16'd1; active_channels = 8'h5A; rng = 3'b011; mode = ~md;
  endtask

  // Monitor: every accepted request must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && req_valid && req_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL req_unexpected: got cfg 0x%0h at edge %0d, expected no request", req_cfg, cyc + 1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("req_cfg", req_cfg, e.cfg);
        check("req_last", req_last, e.last);
        check("req_edge", cyc + 1, e.edge_no);
      end
    end
  end

  // Serial-engine model: conv_done is seen by the DUT resp_delay edges after each transfer.
  always begin
    @(negedge clk);
    conv_done = 1'b0;
    if (!reset && req_valid && req_ready) begin
      repeat (resp_delay) @(negedge clk);
      conv_done = 1'b1;
    end
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step();
    check("rst_req_valid", req_valid, 0);
    check("rst_req_cfg", req_cfg, 0);
    check("rst_req_last", req_last, 0);
    check("rst_in_progress", in_progress, 0);
    check("rst_frames_done", frames_done, 0);
    check("rst_overrun", overrun_cnt, 0);
    check("rst_cfg_error", cfg_error, 0);
    reset = 1'b0;
    step();

    // Basic: channels 0 and 2, three frames 100 cycles apart.
    resp_delay = 5; req_ready = 1'b1;
    S = cyc + 1;
    for (int f = 0; f < 3; f++) begin
      push(8'h8E, 1'b0, S + 1 + 100 * f);
      push(8'hAE, 1'b1, S + 7 + 100 * f);
    end
    start_run(32'd100, 16'd3, 8'h05, 3'b111, 1'b0);
    wait_until(S + 50);
    check("t1_mid_in_progress", in_progress, 1);
    check("t1_mid_frames", frames_done, 1);
    wait_idle(400, fall);
    check("t1_fall_edge", fall, S + 212);
    check("t1_frames", frames_done, 3);
    check("t1_overrun", overrun_cnt, 0);
    check("t1_drained", exp_q.size(), 0);

    // Backpressure: request held stable for 20 cycles with ready low.
    req_ready = 1'b0;
    S = cyc + 1;
    push(8'hB4, 1'b0, S + 21);
    push(8'hC4, 1'b1, S + 27);
    start_run(32'd100, 16'd1, 8'h18, 3'b010, 1'b0);
    stable = 0;
    for (int i = 0; i < 20; i++) begin
      if (req_valid === 1'b1 && req_cfg === 8'hB4 && req_last === 1'b0) stable++;
      step();
    end
    check("t2_hold_stable", stable, 20);
    req_ready = 1'b1;
    wait_idle(200, fall);
    check("t2_fall_edge", fall, S + 32);
    check("t2_frames", frames_done, 1);
    check("t2_drained", exp_q.size(), 0);

    // Overrun: period 40, 60-cycle conversions, two channels -> 3 dropped ticks per frame.
    resp_delay = 60;
    S = cyc + 1;
    push(8'h92, 1'b0, S + 1);
    push(8'hF2, 1'b1, S + 62);
    push(8'h92, 1'b0, S + 161);
    push(8'hF2, 1'b1, S + 222);
    start_run(32'd40, 16'd2, 8'h82, 3'b001, 1'b0);
    wait_until(S + 130);
    check("t3_overrun_f1", overrun_cnt, 3);
    check("t3_frames_f1", frames_done, 1);
    active_channels = 8'h01;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_until(S + 135);
    check("t3_restart_ignored_frames", frames_done, 1);
    check("t3_restart_ignored_overrun", overrun_cnt, 3);
    wait_idle(400, fall);
    check("t3_fall_edge", fall, S + 282);
    check("t3_overrun_total", overrun_cnt, 6);
    check("t3_frames", frames_done, 2);
    check("t3_drained", exp_q.size(), 0);

    // Clamp + continuous round-robin, then abort while waiting for a tick.
    resp_delay = 5;
    S = cyc + 1;
    for (int k = 0; k < 9; k++) push(8'(8'h88 | ((k % 8) << 4)), 1'b1, S + 1 + 32 * k);
    start_run(32'd4, 16'd0, 8'hFF, 3'b100, 1'b1);
    wait_until(S + 270);
    check("t4_in_progress", in_progress, 1);
    check("t4_frames", frames_done, 9);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t4_abort_idle", in_progress, 0);
    check("t4_abort_frames", frames_done, 9);
    check("t4_overrun", overrun_cnt, 0);
    check("t4_drained", exp_q.size(), 0);

    // Abort after transfer: waits for conv_done, frame not counted.
    resp_delay = 30;
    S = cyc + 1;
    push(8'hA0, 1'b1, S + 1);
    start_run(32'd100, 16'd0, 8'h24, 3'b000, 1'b1);
    wait_until(S + 9);
    abort = 1'b1;
    step();
    abort = 1'b0;
    wait_until(S + 20);
    check("t5_still_running", in_progress, 1);
    wait_idle(100, fall);
    check("t5_fall_edge", fall, S + 31);
    check("t5_frames", frames_done, 0);
    check("t5_drained", exp_q.size(), 0);

    // Start+abort together (start wins); pointer carried over from the earlier run.
    resp_delay = 5;
    S = cyc + 1;
    push(8'h90, 1'b1, S + 1);
    push(8'h80, 1'b1, S + 51);
    abort = 1'b1;
    start_run(32'd50, 16'd2, 8'h03, 3'b000, 1'b1);
    abort = 1'b0;
    wait_idle(200, fall);
    check("t6_fall_edge", fall, S + 56);
    check("t6_frames", frames_done, 2);
    check("t6_drained", exp_q.size(), 0);

    // Empty mask: rejected start.
    start_run(32'd100, 16'd1, 8'h00, 3'b000, 1'b0);
    check("t7_cfg_error_pulse", cfg_error, 1);
    check("t7_no_run", in_progress, 0);
    step();
    check("t7_cfg_error_clear", cfg_error, 0);
    check("t7_no_run_later", in_progress, 0);

    // Asynchronous reset in the middle of WAIT_DONE.
    resp_delay = 10;
    S = cyc + 1;
    push(8'h80, 1'b1, S + 1);
    push(8'h80, 1'b1, S + 41);
    start_run(32'd40, 16'd0, 8'h01, 3'b000, 1'b0);
    wait_until(S + 45);
    check("t8_pre_in_progress", in_progress, 1);
    check("t8_pre_frames", frames_done, 1);
    #2;
    reset = 1'b1;
    #1;
    check("t8_req_valid", req_valid, 0);
    check("t8_req_cfg", req_cfg, 0);
    check("t8_req_last", req_last, 0);
    check("t8_in_progress", in_progress, 0);
    check("t8_frames", frames_done, 0);
    check("t8_overrun", overrun_cnt, 0);
    check("t8_cfg_error", cfg_error, 0);
    check("t8_drained", exp_q.size(), 0);
    step();
    reset = 1'b0;
    repeat (20) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
